// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;

  typedef enum logic [1:0] {
    FETCH,
    DRAIN,
    HOLD,
    HALT
  } fetch_state_t;

  localparam logic [31:0] HALT_WORD_DEF = 32'hFC000000;
  localparam int INST_BYTES = 4;

endpackage

// File: rtl/inst_byte_assembler.sv
// Shifts returning memory bytes into a big-endian word.
// A capture-valid bit tracks which read returns belong to the current PC.
module inst_byte_assembler
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        capture,
  input  logic [7:0]  rdata,
  output logic [31:0] word_next,
  output logic        complete
);

  logic [23:0] shreg;
  logic        cap_vld;
  logic [1:0]  count;

  assign word_next = {shreg, rdata};
  assign complete  = cap_vld && (count == 2'd3);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      shreg   <= '0;
      cap_vld <= 1'b0;
      count   <= '0;
    end else begin
      cap_vld <= capture;
      if (cap_vld) begin
        shreg <= word_next[23:0];
        count <= count + 2'd1;
      end
    end
  end

endmodule

// File: rtl/instruction_fetch_sequencer.sv
// PC register, fetch FSM, range check and decode handshake.
// Reads four bytes per instruction and presents the assembled word.
module instruction_fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int          MEM_BYTES = 256,
  parameter logic [31:0] RESET_PC  = 32'h0,
  parameter logic [31:0] HALT_WORD = HALT_WORD_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         redirect_valid,
  input  logic [31:0]                  redirect_pc,
  output logic                         mem_rd,
  output logic [$clog2(MEM_BYTES)-1:0] mem_addr,
  input  logic [7:0]                   mem_rdata,
  output logic                         inst_valid,
  input  logic                         inst_ready,
  output logic [31:0]                  inst,
  output logic [31:0]                  inst_pc,
  output logic                         halted
);

  localparam int AW = $clog2(MEM_BYTES);
  localparam logic [31:0] LAST_PC = 32'(MEM_BYTES - INST_BYTES);

  fetch_state_t state, nxt_state;
  logic [31:0]  pc, nxt_pc;
  logic [1:0]   k, nxt_k;
  logic         halt_flag, nxt_halt_flag;
  logic         go, nxt_go;
  logic [31:0]  nxt_inst, nxt_inst_pc;
  logic         nxt_inst_valid;
  logic         in_range;
  logic [31:0]  word_next;
  logic         complete;

  assign in_range = (pc <= LAST_PC);
  // go holds off the first read for one cycle so mem_rd reads 0 after reset
  assign mem_rd   = (state == FETCH) && go && in_range;
  assign mem_addr = mem_rd ? (pc[AW-1:0] + AW'(k)) : '0;
  assign halted   = (state == HALT);

  inst_byte_assembler u_asm (
    .clk       (clk),
    .reset     (reset),
    .clear     (redirect_valid),
    .capture   (mem_rd),
    .rdata     (mem_rdata),
    .word_next (word_next),
    .complete  (complete)
  );

  always_comb begin
    nxt_state      = state;
    nxt_pc         = pc;
    nxt_k          = k;
    nxt_halt_flag  = halt_flag;
    nxt_go         = 1'b1;
    nxt_inst       = inst;
    nxt_inst_pc    = inst_pc;
    nxt_inst_valid = inst_valid;
    unique case (state)
      FETCH: begin
        if (go) begin
          if (in_range) begin
            nxt_k = k + 2'd1;
            if (k == 2'd3) nxt_state = DRAIN;
          end else begin
            nxt_inst       = HALT_WORD;
            nxt_inst_pc    = pc;
            nxt_inst_valid = 1'b1;
            nxt_halt_flag  = 1'b1;
            nxt_state      = HOLD;
          end
        end
      end
      DRAIN: begin
        if (complete) begin
          nxt_inst       = word_next;
          nxt_inst_pc    = pc;
          nxt_inst_valid = 1'b1;
          nxt_state      = HOLD;
        end
      end
      HOLD: begin
        if (inst_ready) begin
          nxt_inst_valid = 1'b0;
          if (halt_flag) begin
            nxt_state = HALT;
          end else begin
            nxt_pc    = pc + 32'd4;
            nxt_k     = '0;
            nxt_state = FETCH;
          end
        end
      end
      HALT: begin
        nxt_state = HALT;
      end
      default: nxt_state = FETCH;
    endcase
    // redirect overrides everything; a HOLD handshake still retires
    if (redirect_valid) begin
      nxt_state      = FETCH;
      nxt_pc         = redirect_pc;
      nxt_k          = '0;
      nxt_halt_flag  = 1'b0;
      nxt_inst_valid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      k          <= '0;
      halt_flag  <= 1'b0;
      go         <= 1'b0;
      inst       <= '0;
      inst_pc    <= '0;
      inst_valid <= 1'b0;
    end else begin
      state      <= nxt_state;
      pc         <= nxt_pc;
      k          <= nxt_k;
      halt_flag  <= nxt_halt_flag;
      go         <= nxt_go;
      inst       <= nxt_inst;
      inst_pc    <= nxt_inst_pc;
      inst_valid <= nxt_inst_valid;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_sequencer.sv
// Directed bench with a scoreboard of expected instructions.
module tb_instruction_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        mem_rd;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        halted;

  int total = 0;
  int bad = 0;
  logic [63:0] exp_q[$];
  logic [7:0]  mem [256];

  always #5 clk = ~clk;

  instruction_fetch_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mem_rd         (mem_rd),
    .mem_addr       (mem_addr),
    .mem_rdata      (mem_rdata),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .halted         (halted)
  );

  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= mem[mem_addr];
    else mem_rdata <= 8'h5A;
  end

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && inst_valid && inst_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_inst: got %h @%h want none",
                 inst, inst_pc);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        chk("sb_inst", inst, e[63:32]);
        chk("sb_pc", inst_pc, e[31:0]);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rd(input string name);
    int n = 0;
    while (!mem_rd && n < 20) begin
      step();
      n++;
    end
    chk(name, {31'b0, mem_rd}, 32'd1);
  endtask

  task automatic wait_hold(input string name, input logic [31:0] pc);
    int n = 0;
    while (!(inst_valid && inst_pc == pc) && n < 40) begin
      step();
      n++;
    end
    chk(name, {31'b0, inst_valid && inst_pc == pc}, 32'd1);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_valid"}, {31'b0, inst_valid}, 32'd0);
    chk({tag, "_inst"}, inst, 32'd0);
    chk({tag, "_pc"}, inst_pc, 32'd0);
    chk({tag, "_rd"}, {31'b0, mem_rd}, 32'd0);
    chk({tag, "_addr"}, {24'b0, mem_addr}, 32'd0);
    chk({tag, "_halted"}, {31'b0, halted}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'hEE;
    mem[0] = 8'h12; mem[1] = 8'h34; mem[2] = 8'h56; mem[3] = 8'h78;
    mem[4] = 8'h9A; mem[5] = 8'hBC; mem[6] = 8'hDE; mem[7] = 8'hF0;
    mem[8] = 8'h55; mem[9] = 8'h66; mem[10] = 8'h77; mem[11] = 8'h88;
    mem[40] = 8'h11; mem[41] = 8'h22; mem[42] = 8'h33; mem[43] = 8'h44;
    mem[252] = 8'hA1; mem[253] = 8'hB2;
    mem[254] = 8'hC3; mem[255] = 8'hD4;

    reset = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    inst_ready = 1'b1;
    step(); step(); step();
    chk_reset_outs("rst");

    reset = 1'b0;
    exp_q.push_back({32'h12345678, 32'd0});
    wait_rd("first_rd");
    for (int k = 0; k < 4; k++) begin
      chk("first_rd_k", {31'b0, mem_rd}, 32'd1);
      chk("first_addr_k", {24'b0, mem_addr}, k);
      step();
    end
    chk("drain_valid", {31'b0, inst_valid}, 32'd0);
    chk("drain_rd", {31'b0, mem_rd}, 32'd0);
    step();
    chk("first_valid", {31'b0, inst_valid}, 32'd1);
    chk("first_inst", inst, 32'h12345678);
    step();
    chk("next_addr", {24'b0, mem_addr}, 32'd4);
    chk("next_rd", {31'b0, mem_rd}, 32'd1);

    inst_ready = 1'b0;
    exp_q.push_back({32'h9ABCDEF0, 32'd4});
    wait_hold("bp_wait", 32'd4);
    for (int i = 0; i < 10; i++) begin
      chk("bp_inst", inst, 32'h9ABCDEF0);
      chk("bp_pc", inst_pc, 32'd4);
      chk("bp_rd", {31'b0, mem_rd}, 32'd0);
      step();
    end
    inst_ready = 1'b1;
    step();
    chk("bp_after_addr", {24'b0, mem_addr}, 32'd8);
    chk("bp_after_valid", {31'b0, inst_valid}, 32'd0);
    step(); step();
    chk("mid_k2_addr", {24'b0, mem_addr}, 32'd10);
    redirect_valid = 1'b1;
    redirect_pc = 32'd40;
    exp_q.push_back({32'h11223344, 32'd40});
    exp_q.push_back({32'hEEEEEEEE, 32'd44});
    step();
    redirect_valid = 1'b0;
    chk("mid_redir_addr", {24'b0, mem_addr}, 32'd40);

    wait_hold("sim_wait", 32'd44);
    redirect_valid = 1'b1;
    redirect_pc = 32'd252;
    exp_q.push_back({32'hA1B2C3D4, 32'd252});
    step();
    redirect_valid = 1'b0;
    inst_ready = 1'b0;
    chk("sim_valid", {31'b0, inst_valid}, 32'd0);
    chk("sim_addr", {24'b0, mem_addr}, 32'd252);
    chk("sim_rd", {31'b0, mem_rd}, 32'd1);

    wait_hold("top_wait", 32'd252);
    chk("top_inst", inst, 32'hA1B2C3D4);
    inst_ready = 1'b1;
    exp_q.push_back({32'hFC000000, 32'd256});
    step();
    chk("wrap_rd", {31'b0, mem_rd}, 32'd0);
    step();
    chk("wrap_valid", {31'b0, inst_valid}, 32'd1);
    chk("wrap_inst", inst, 32'hFC000000);
    chk("wrap_halted", {31'b0, halted}, 32'd0);
    step();
    for (int i = 0; i < 3; i++) begin
      chk("halt_halted", {31'b0, halted}, 32'd1);
      chk("halt_rd", {31'b0, mem_rd}, 32'd0);
      step();
    end

    redirect_valid = 1'b1;
    redirect_pc = 32'd253;
    exp_q.push_back({32'hFC000000, 32'd253});
    step();
    redirect_valid = 1'b0;
    chk("r253_halted", {31'b0, halted}, 32'd0);
    chk("r253_rd", {31'b0, mem_rd}, 32'd0);
    step();
    inst_ready = 1'b0;
    chk("r253_valid", {31'b0, inst_valid}, 32'd1);
    chk("r253_inst", inst, 32'hFC000000);
    chk("r253_pc", inst_pc, 32'd253);
    step(); step();
    chk("r253_hold_halted", {31'b0, halted}, 32'd0);
    inst_ready = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      chk("r253_halted_on", {31'b0, halted}, 32'd1);
      step();
    end

    redirect_valid = 1'b1;
    redirect_pc = 32'd8;
    step();
    redirect_valid = 1'b0;
    chk("rmid_addr0", {24'b0, mem_addr}, 32'd8);
    step();
    chk("rmid_addr1", {24'b0, mem_addr}, 32'd9);
    reset = 1'b1;
    step();
    chk_reset_outs("rmid");
    reset = 1'b0;
    exp_q.push_back({32'h12345678, 32'd0});
    wait_rd("restart_rd");
    chk("restart_addr", {24'b0, mem_addr}, 32'd0);
    wait_hold("restart_wait", 32'd0);
    step(); step();

    chk("queue_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
